dtc_thermo_decoder: RTL and testbench
=====================================

Name: dtc_thermo_decoder

Overview:
- Reverse direction of the TDC encoder path: takes a Q6.10 delay-line tap position and drives the 64-bit thermometer control word of the digitally-controlled delay line (DTC) in the DPLL.
- Optional first-order fractional dither; integer part slewed toward target with a bounded step per clock to avoid delay-line glitches.
- Sits between loop-filter/DCO control logic (code producer) and the DTC tap-enable bus.

Parameters:
- N_TAPS, 64, thermometer width; max tap = N_TAPS-1.
- INT_W, 6, integer bits of code_in.
- FRAC_W, 10, fractional bits of code_in.
- MAX_STEP, 4, max tap change per clock in SLEW (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_valid  in  1  code_in valid.
- code_in  in  16  tap position, Q6.10 ({int[15:10], frac[9:0]}).
- code_ready  out  1  high only in IDLE; transfer on code_valid & code_ready at a rising edge.
- dither_en  in  1  1 = fractional accumulator dither; 0 = round-half-up.
- inv_dir  in  1  1 = thermo_out bitwise inverted.
- thermo_out  out  64  registered: bit i = (i < cur_tap) XOR inv_dir.
- tap_out  out  6  current applied tap (cur_tap).
- upd_done  out  1  one-cycle pulse when cur_tap reaches target.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cur_tap=0, target=0, acc=0, thermo_out=64'h0, tap_out=0, upd_done=0, code_ready=1. Reset mid-SLEW aborts immediately to these values; no upd_done.
- code_ready = (state==IDLE), derived from registered state.
- FSM: IDLE -> CALC on accept (edge E0, code_in captured). CALC -> SLEW after one cycle (E1). SLEW -> IDLE at the edge where cur_tap becomes target; upd_done=1 on that same edge for one cycle.
- CALC (at E1):
  - dither_en=1: sum = acc + frac (11 bits); acc <= sum[9:0]; target = int + sum[10].
  - dither_en=0: target = int + frac[9]; acc held.
  - target = int + 1 with int=63: saturate to 63.
- SLEW, per edge from E2:
  - If |target-cur_tap| <= MAX_STEP: cur_tap <= target; done.
  - Else cur_tap moves MAX_STEP toward target.
  - target==cur_tap at entry: one SLEW cycle, upd_done at E2, cur_tap unchanged.
  - SLEW cycles = max(1, ceil(|delta|/MAX_STEP)).
  - Minimum latency accept→upd_done: 2 edges.
- thermo_out and tap_out are registered from next cur_tap and current inv_dir every edge, in every state. inv_dir change is visible one edge later, no state change.
- code_valid while code_ready=0 is ignored, not queued. Producer holds code_valid until accepted.
- dither_en is sampled only in CALC.
- Width rules: all tap arithmetic in 7-bit unsigned, no wrap. cur_tap and target are always in 0..63. thermo_out bit 63 is set only via inv_dir.

Test Plan:
- Reset check: assert rst_n=0 mid-operation -> immediately thermo_out=0, tap_out=0, upd_done=0, code_ready=1. Release, hold idle 5 cycles -> outputs unchanged.
- Small step: dither_en=0, cur_tap=0, code_in=16'h0C00 (3.0) accepted at E0 -> at E2 tap_out=3, thermo_out=64'h7, upd_done=1 for exactly one cycle, code_ready=1 from E2.
- Slew: code_in=16'hA000 (40.0) from tap 0 -> tap_out 4,8,...,40 on 10 consecutive edges. upd_done only with 40. code_ready=0 throughout. A code_valid pulse mid-slew is ignored.
- Dither: dither_en=1, acc=0, tap 5, code_in=16'h1500 (5.25) four times -> targets 5,5,5,6; acc 256,512,768,0. Then dither_en=0 with 16'h1600 (5.5) -> target 6, acc unchanged.
- Saturation/down-slew: code_in=16'hFF00 (63.75), dither_en=0 -> target 63, thermo_out=64'h7FFF_FFFF_FFFF_FFFF. Then code 16'h0000 -> 16 slew cycles down to 0.
- Polarity: tap 3, toggle inv_dir=1 in IDLE -> next edge thermo_out=64'hFFFF_FFFF_FFFF_FFF8, tap_out=3, no upd_done, code_ready stays 1.

Source files
------------

// File: rtl/dtc_thermo_decoder.sv
// ---------------------------------------------------------------------------
// dtc_thermo_decoder
//
// Turns a fixed-point delay-line tap position into the thermometer control
// word of the digitally-controlled delay line. The fractional part is either
// rounded half-up or dithered with a first-order accumulator. The applied tap
// then moves toward the new target by at most MAX_STEP taps per clock, so the
// delay line never sees a large jump in a single cycle.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   code_valid  code_in is valid (producer holds it until accepted)
//   code_in     tap position, unsigned {int[INT_W-1:0], frac[FRAC_W-1:0]}
//   code_ready  high only while idle; transfer on code_valid & code_ready
//   dither_en   1 = fractional accumulator dither, 0 = round-half-up
//   inv_dir     1 = thermometer word bitwise inverted
//   thermo_out  registered thermometer word, bit i = (i < tap) ^ inv_dir
//   tap_out     currently applied tap
//   upd_done    one-cycle pulse on the edge where the tap reaches its target
// ---------------------------------------------------------------------------
module dtc_thermo_decoder #(
    parameter int N_TAPS   = 64,
    parameter int INT_W    = 6,
    parameter int FRAC_W   = 10,
    parameter int MAX_STEP = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      code_valid,
    input  logic [INT_W+FRAC_W-1:0]   code_in,
    output logic                      code_ready,
    input  logic                      dither_en,
    input  logic                      inv_dir,
    output logic [N_TAPS-1:0]         thermo_out,
    output logic [INT_W-1:0]          tap_out,
    output logic                      upd_done
);

    localparam int CODE_W = INT_W + FRAC_W;
    // One extra bit so that int + carry can be seen to exceed the top tap.
    localparam int AW = INT_W + 1;
    localparam logic [AW-1:0]    MAX_TAP_W = AW'(N_TAPS - 1);
    localparam logic [AW-1:0]    STEP_W    = AW'(MAX_STEP);
    localparam logic [INT_W-1:0] STEP_T    = INT_W'(MAX_STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SLEW
    } state_t;

    state_t              state_reg;
    logic [CODE_W-1:0]   code_reg;
    logic [INT_W-1:0]    target_reg;
    logic [INT_W-1:0]    cur_tap_reg;
    logic [FRAC_W-1:0]   acc_reg;
    logic                upd_done_reg;
    logic [N_TAPS-1:0]   thermo_reg;

    logic [INT_W-1:0]    code_int;
    logic [FRAC_W-1:0]   code_frac;
    logic [FRAC_W:0]     dither_sum;
    logic                round_carry;
    logic [AW-1:0]       target_wide;
    logic [INT_W-1:0]    target_calc;

    logic [AW-1:0]       cur_w;
    logic [AW-1:0]       tgt_w;
    logic                slew_up;
    logic [AW-1:0]       slew_dist;
    logic                slew_hit;
    logic [INT_W-1:0]    cur_tap_next;
    logic [N_TAPS-1:0]   thermo_next;

    // -----------------------------------------------------------------------
    // Target computation (used on the CALC cycle)
    // -----------------------------------------------------------------------
    always_comb begin
        code_int    = code_reg[CODE_W-1:FRAC_W];
        code_frac   = code_reg[FRAC_W-1:0];
        dither_sum  = {1'b0, acc_reg} + {1'b0, code_frac};
        // Dither: carry out of the accumulator; otherwise round half up on
        // the fractional MSB.
        round_carry = dither_en ? dither_sum[FRAC_W] : code_frac[FRAC_W-1];
        target_wide = {1'b0, code_int} + AW'(round_carry);
        target_calc = (target_wide > MAX_TAP_W) ? MAX_TAP_W[INT_W-1:0]
                                                : target_wide[INT_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Bounded slew of the applied tap toward the target
    // -----------------------------------------------------------------------
    always_comb begin
        cur_w     = {1'b0, cur_tap_reg};
        tgt_w     = {1'b0, target_reg};
        slew_up   = (tgt_w >= cur_w);
        slew_dist = slew_up ? (tgt_w - cur_w) : (cur_w - tgt_w);
        slew_hit  = (slew_dist <= STEP_W);

        cur_tap_next = cur_tap_reg;
        if (state_reg == ST_SLEW) begin
            if (slew_hit) begin
                cur_tap_next = target_reg;
            end else if (slew_up) begin
                // Distance exceeds the step, so neither direction can wrap.
                cur_tap_next = cur_tap_reg + STEP_T;
            end else begin
                cur_tap_next = cur_tap_reg - STEP_T;
            end
        end
    end

    // Thermometer word for the tap that will be applied after this edge.
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_thermo
            assign thermo_next[gi] = (AW'(gi) < {1'b0, cur_tap_next}) ^ inv_dir;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            code_reg     <= '0;
            target_reg   <= '0;
            cur_tap_reg  <= '0;
            acc_reg      <= '0;
            upd_done_reg <= 1'b0;
            thermo_reg   <= '0;
        end else begin
            cur_tap_reg  <= cur_tap_next;
            thermo_reg   <= thermo_next;
            upd_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (code_valid) begin
                        code_reg  <= code_in;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    target_reg <= target_calc;
                    if (dither_en) begin
                        acc_reg <= dither_sum[FRAC_W-1:0];
                    end
                    state_reg <= ST_SLEW;
                end
                ST_SLEW: begin
                    if (slew_hit) begin
                        upd_done_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign code_ready = (state_reg == ST_IDLE);
    assign tap_out    = cur_tap_reg;
    assign thermo_out = thermo_reg;
    assign upd_done   = upd_done_reg;

endmodule

// File: tb/tb_dtc_thermo_decoder.sv
// ---------------------------------------------------------------------------
// tb_dtc_thermo_decoder
//
// Table of directed transfers (small step, long slew with an ignored
// mid-slew request, dither sequence, saturation, full down-slew), polarity
// and reset sequences, then randomized transfers checked against a
// tap-position model built from the arithmetic rules of the decoder.
// ---------------------------------------------------------------------------
module tb_dtc_thermo_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [15:0] code_in = '0;
    logic        code_ready;
    logic        dither_en = 1'b0;
    logic        inv_dir = 1'b0;
    logic [63:0] thermo_out;
    logic [5:0]  tap_out;
    logic        upd_done;

    dtc_thermo_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code_in    (code_in),
        .code_ready (code_ready),
        .dither_en  (dither_en),
        .inv_dir    (inv_dir),
        .thermo_out (thermo_out),
        .tap_out    (tap_out),
        .upd_done   (upd_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: applied tap and dither accumulator.
    int m_cur = 0;
    int m_acc = 0;

    typedef struct {
        logic [15:0] code;
        bit          dith;
        bit          noise;
        int          exp_tap;
        int          exp_slews;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] therm(input int tap, input bit inv);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < tap; i++) t[i] = 1'b1;
        return inv ? ~t : t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int tap, input bit upd, input bit rdy);
        chk({tag, "_tap"},    64'(tap_out),    64'(tap));
        chk({tag, "_thermo"}, thermo_out,      therm(tap, inv_dir));
        chk({tag, "_upd"},    64'(upd_done),   64'(upd));
        chk({tag, "_ready"},  64'(code_ready), 64'(rdy));
    endtask

    // Target from the code: integer part plus round-half-up or dither carry,
    // clamped to the top tap.
    task automatic model_target(input logic [15:0] code, input bit d, output int t);
        int ip, fr, s;
        ip = int'(code[15:10]);
        fr = int'(code[9:0]);
        if (d) begin
            s     = m_acc + fr;
            m_acc = s % 1024;
            t     = ip + s / 1024;
        end else begin
            t = ip + ((fr >= 512) ? 1 : 0);
        end
        if (t > 63) t = 63;
    endtask

    // One complete transfer. Called and returns at a falling edge.
    task automatic xfer(input logic [15:0] code, input bit d, input bit noise,
                        output int slews);
        int  tgt, diff;
        bit  done;
        chk("pre_ready", 64'(code_ready), 64'd1);
        code_valid = 1'b1;
        code_in    = code;
        dither_en  = d;
        @(negedge clk);                  // after E0: captured, in CALC
        code_valid = 1'b0;
        chk_outs("calc", m_cur, 1'b0, 1'b0);
        model_target(code, d, tgt);
        @(negedge clk);                  // after E1: target computed
        dither_en = ~d;                  // must not matter from here on
        chk_outs("slew0", m_cur, 1'b0, 1'b0);
        slews = 0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            slews++;
            diff = tgt - m_cur;
            if (diff >= -4 && diff <= 4) begin
                m_cur = tgt;
                done  = 1'b1;
            end else begin
                m_cur = m_cur + ((diff > 0) ? 4 : -4);
            end
            chk_outs("slew", m_cur, done, done);
            if (noise) begin
                // A request during the slew must be ignored, not queued.
                code_valid = (k == 1);
                code_in    = 16'h3C00;
            end
        end
        code_valid = 1'b0;
        if (!done) chk("slew_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk_outs("post", m_cur, 1'b0, 1'b1);
        $display("xfer code=%h dither=%0d inv=%0d -> tap=%0d slews=%0d", code, d, inv_dir,
                 tap_out, slews);
    endtask

    initial begin
        int slews;
        int t0;

        // Reset state and idle hold.
        repeat (2) @(negedge clk);
        chk_outs("rst", 0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outs("idle", 0, 1'b0, 1'b1);
        end

        // Directed table: code, dither, noise, expected tap, expected slews.
        vecs.push_back('{16'h0C00, 1'b0, 1'b0,  3,  1});  // 3.0 from 0
        vecs.push_back('{16'h0000, 1'b0, 1'b0,  0,  1});
        vecs.push_back('{16'hA000, 1'b0, 1'b1, 40, 10});  // 40.0, request mid-slew
        vecs.push_back('{16'h1400, 1'b0, 1'b0,  5,  9});  // 40 -> 5
        vecs.push_back('{16'h1500, 1'b1, 1'b0,  5,  1});  // acc 256
        vecs.push_back('{16'h1500, 1'b1, 1'b0,  5,  1});  // acc 512
        vecs.push_back('{16'h1500, 1'b1, 1'b0,  5,  1});  // acc 768
        vecs.push_back('{16'h1500, 1'b1, 1'b0,  6,  1});  // carry, acc 0
        vecs.push_back('{16'h1600, 1'b0, 1'b0,  6,  1});  // 5.5 rounds up
        vecs.push_back('{16'hFF00, 1'b0, 1'b0, 63, 15});  // 63.75 saturates
        vecs.push_back('{16'h0000, 1'b0, 1'b0,  0, 16});  // full down-slew
        vecs.push_back('{16'h0C00, 1'b0, 1'b0,  3,  1});
        foreach (vecs[i]) begin
            xfer(vecs[i].code, vecs[i].dith, vecs[i].noise, slews);
            chk("vec_tap",   64'(tap_out), 64'(vecs[i].exp_tap));
            chk("vec_slews", 64'(slews),   64'(vecs[i].exp_slews));
        end
        chk("sat_thermo_pre", therm(63, 1'b0), 64'h7FFF_FFFF_FFFF_FFFF);

        // Polarity: tap 3, invert in idle.
        inv_dir = 1'b1;
        @(negedge clk);
        chk("pol_thermo", thermo_out, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("pol_tap",    64'(tap_out), 64'd3);
        chk("pol_upd",    64'(upd_done), 64'd0);
        chk("pol_ready",  64'(code_ready), 64'd1);
        $display("polarity inv=1 thermo=%h", thermo_out);
        inv_dir = 1'b0;
        @(negedge clk);
        chk("pol_back", thermo_out, 64'h7);

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                inv_dir = ~inv_dir;
                @(negedge clk);
                chk_outs("rnd_inv", m_cur, 1'b0, 1'b1);
            end
            xfer(16'($urandom), 1'($urandom), 1'b0, slews);
        end

        // Reset in the middle of a slew.
        inv_dir = 1'b0;
        xfer(16'h0000, 1'b0, 1'b0, slews);
        code_valid = 1'b1;
        code_in    = 16'hA000;
        dither_en  = 1'b0;
        @(negedge clk);
        code_valid = 1'b0;
        t0 = 0;
        repeat (4) @(negedge clk);
        chk("mid_tap", 64'(tap_out), 64'd12);
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        m_cur = 0;
        m_acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outs("rst_idle", 0, 1'b0, 1'b1);
        end
        $display("reset mid-slew tap=%0d ready=%0d", tap_out, code_ready);

        // Accumulator must have been cleared: 5.25 with dither -> 5.
        xfer(16'h1500, 1'b1, 1'b0, slews);
        chk("acc_cleared", 64'(tap_out), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
